// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq -- instruction-cycle sequencer for the 32-bit CPU.
//
// Steps each instruction through fetch, decode, operand read, execute and
// write-back. It is the only master on the shared single-port memory.
// It also drives the IR load strobe, the ALU latch and execute strobes,
// and the PC increment and load strobes.
//
// Optional feature: define SINGLE_STEP_EN to add the 'step' input and a WAIT
// state. Every return to FETCH then parks in WAIT until a rising edge of step.
// Reset also lands in WAIT.
//
// Ports
//   clock, reset       system clock; synchronous active-low reset
//   step               (SINGLE_STEP_EN only) single-step release
//   op, cc             IR opcode and condition mask {N,Z,C,V}
//   s_a, de_a          IR source / destination (jump target) addresses
//   pc                 current program counter
//   flags              ALU status {N,Z,C,V}
//   mem_ready          memory access complete; read data valid this cycle
//   ir_cmd             IR load strobe
//   src_ld, dst_ld     ALU operand latch strobes
//   alu_en             ALU execute strobe
//   mem_rd, mem_wr     memory read/write requests
//   mem_addr           memory address
//   pc_inc, pc_load    PC increment / load-from-de_a strobes
//   halted             high in HALT
//   dbg_state          current state encoding
//                      (FETCH=0 DECODE=1 RD_SRC=2 RD_DST=3 EXEC=4 WR_DST=5 HALT=6 WAIT=7)
//
// Memory handshake: a request (mem_rd or mem_wr) with its mem_addr is held
// unchanged until mem_ready is sampled high. That cycle completes the access.
// The read-data strobes (ir_cmd/src_ld/dst_ld) are combinational on mem_ready
// in that same cycle.
module cpu_ctrl_seq #(
   parameter int ADDR_W = 12
) (
   input  logic              clock,
   input  logic              reset,
`ifdef SINGLE_STEP_EN
   input  logic              step,
`endif
   input  logic [3:0]        op,
   input  logic [3:0]        cc,
   input  logic [ADDR_W-1:0] s_a,
   input  logic [ADDR_W-1:0] de_a,
   input  logic [ADDR_W-1:0] pc,
   input  logic [3:0]        flags,
   input  logic              mem_ready,
   output logic              ir_cmd,
   output logic              src_ld,
   output logic              dst_ld,
   output logic              alu_en,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              pc_inc,
   output logic              pc_load,
   output logic              halted,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      RD_SRC = 3'd2,
      RD_DST = 3'd3,
      EXEC   = 3'd4,
      WR_DST = 3'd5,
      HALT   = 3'd6
`ifdef SINGLE_STEP_EN
      , WAIT = 3'd7
`endif
   } state_t;

   localparam logic [3:0] OP_MOV = 4'h8;
   localparam logic [3:0] OP_JMP = 4'h9;
   localparam logic [3:0] OP_HLT = 4'hF;

   // End of every instruction (and reset) goes here.
`ifdef SINGLE_STEP_EN
   localparam state_t RET_ST = WAIT;
`else
   localparam state_t RET_ST = FETCH;
`endif

   state_t state_q, state_d;
   logic   jmp_taken;

`ifdef SINGLE_STEP_EN
   logic step_q, step_d;
   logic step_rise;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= RET_ST;
`ifdef SINGLE_STEP_EN
         step_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
`ifdef SINGLE_STEP_EN
         step_q  <= step_d;
`endif
      end
   end

   // An empty condition mask means an unconditional jump.
   assign jmp_taken = (cc == 4'd0) || (|(cc & flags));
   assign dbg_state = state_q;

   always_comb begin
      state_d  = state_q;
      ir_cmd   = 1'b0;
      src_ld   = 1'b0;
      dst_ld   = 1'b0;
      alu_en   = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      mem_addr = '0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      halted   = 1'b0;
`ifdef SINGLE_STEP_EN
      step_d    = step;
      step_rise = step && !step_q;
`endif

      case (state_q)
         FETCH: begin
            mem_rd   = 1'b1;
            mem_addr = pc;
            if (mem_ready) begin
               ir_cmd  = 1'b1;
               pc_inc  = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            // 0x1-0x7 are ALU ops, 0x8 is MOV; both start with the source read.
            // 0x0 and the unused 0xA-0xE fall through as NOP.
            if (op >= 4'h1 && op <= OP_MOV) begin
               state_d = RD_SRC;
            end else if (op == OP_JMP) begin
               pc_load = jmp_taken;
               state_d = RET_ST;
            end else if (op == OP_HLT) begin
               state_d = HALT;
            end else begin
               state_d = RET_ST;
            end
         end
         RD_SRC: begin
            mem_rd   = 1'b1;
            mem_addr = s_a;
            if (mem_ready) begin
               src_ld  = 1'b1;
               // MOV writes the source word straight back; no second operand.
               state_d = (op == OP_MOV) ? WR_DST : RD_DST;
            end
         end
         RD_DST: begin
            mem_rd   = 1'b1;
            mem_addr = de_a;
            if (mem_ready) begin
               dst_ld  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            alu_en  = 1'b1;
            state_d = WR_DST;
         end
         WR_DST: begin
            mem_wr   = 1'b1;
            mem_addr = de_a;
            if (mem_ready) state_d = RET_ST;
         end
         HALT: begin
            halted = 1'b1;
         end
`ifdef SINGLE_STEP_EN
         WAIT: begin
            if (step_rise) state_d = FETCH;
         end
`endif
         default: state_d = RET_ST;
      endcase

      // While reset is asserted the outputs are quiet, even mid-access.
      if (!reset) begin
         ir_cmd   = 1'b0;
         src_ld   = 1'b0;
         dst_ld   = 1'b0;
         alu_en   = 1'b0;
         mem_rd   = 1'b0;
         mem_wr   = 1'b0;
         mem_addr = '0;
         pc_inc   = 1'b0;
         pc_load  = 1'b0;
         halted   = 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: memory model with wait states, PC model, and an
// expected-access queue filled per instruction and drained on each handshake.
module tb_cpu_ctrl_seq;
   localparam int ADDR_W = 12;
   localparam logic [2:0] ST_FETCH = 3'd0;
   localparam logic [2:0] ST_HALT  = 3'd6;
   localparam logic [2:0] ST_WAIT  = 3'd7;
`ifdef SINGLE_STEP_EN
   localparam logic [2:0] ST_IDLE = ST_WAIT;
`else
   localparam logic [2:0] ST_IDLE = ST_FETCH;
`endif

   logic              clock = 1'b0;
   logic              reset;
`ifdef SINGLE_STEP_EN
   logic              step;
`endif
   logic [3:0]        op, cc, flags;
   logic [ADDR_W-1:0] s_a, de_a, pc;
   logic              mem_ready;
   logic              ir_cmd, src_ld, dst_ld, alu_en, mem_rd, mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic              pc_inc, pc_load, halted;
   logic [2:0]        dbg_state;

   int total = 0;
   int bad   = 0;
   logic [ADDR_W:0]   exp_q[$];   // {is_write, addr}
   logic [ADDR_W-1:0] pc_model;

   always #5 clock = ~clock;

   cpu_ctrl_seq #(.ADDR_W(ADDR_W)) dut (
      .clock     (clock),
      .reset     (reset),
`ifdef SINGLE_STEP_EN
      .step      (step),
`endif
      .op        (op),
      .cc        (cc),
      .s_a       (s_a),
      .de_a      (de_a),
      .pc        (pc),
      .flags     (flags),
      .mem_ready (mem_ready),
      .ir_cmd    (ir_cmd),
      .src_ld    (src_ld),
      .dst_ld    (dst_ld),
      .alu_en    (alu_en),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .pc_inc    (pc_inc),
      .pc_load   (pc_load),
      .halted    (halted),
      .dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] outs_vec();
      return {ir_cmd, src_ld, dst_ld, alu_en, mem_rd, mem_wr, pc_inc, pc_load, halted};
   endfunction

   task automatic step_release();
`ifdef SINGLE_STEP_EN
      @(negedge clock);
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
`endif
   endtask

   // Runs one instruction from FETCH until it returns (or halts).
   // src_ws sets the wait states of the source read. rnd_ws randomises the rest.
   task automatic run_instr(input string tag, input logic [3:0] op_i, input logic [3:0] cc_i,
                            input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] da,
                            input logic [3:0] fl, input int src_ws, input bit rnd_ws);
      int waits[4];
      int n_acc, exp_cyc, cyc, acc, wcnt, req_cyc, w;
      int n_alu, n_inc, n_load, n_ir, n_src, n_dst, n_both;
      bit is_alu, is_mov, taken, done, left, moved;
      logic [ADDR_W:0]   exp_acc;
      logic [ADDR_W-1:0] held_addr;
      op = op_i; cc = cc_i; s_a = sa; de_a = da; flags = fl;
      is_alu = (op_i >= 4'h1) && (op_i <= 4'h7);
      is_mov = (op_i == 4'h8);
      taken  = (op_i == 4'h9) && ((cc_i == 4'd0) || ((cc_i & fl) != 4'd0));
      exp_q.delete();
      exp_q.push_back({1'b0, pc_model});
      if (is_alu || is_mov) exp_q.push_back({1'b0, sa});
      if (is_alu) exp_q.push_back({1'b0, da});
      if (is_alu || is_mov) exp_q.push_back({1'b1, da});
      n_acc   = exp_q.size();
      exp_cyc = is_alu ? 6 : (is_mov ? 4 : 2);
      for (int k = 0; k < 4; k++) begin
         waits[k] = (k == 1) ? src_ws : (rnd_ws ? int'($urandom_range(0, 2)) : 0);
         if (k < n_acc) exp_cyc += waits[k];
      end
      step_release();
      cyc = 0; acc = 0; wcnt = 0; req_cyc = 0; done = 0; left = 0; moved = 0;
      n_alu = 0; n_inc = 0; n_load = 0; n_ir = 0; n_src = 0; n_dst = 0; n_both = 0;
      held_addr = '0;
      while (!done && cyc < 60) begin
         @(negedge clock);
         pc = pc_model;
         mem_ready = 1'b0;
         w = (acc < 4) ? waits[acc] : 0;
         if (mem_rd || mem_wr) begin
            if (wcnt < w) wcnt++;
            else mem_ready = 1'b1;
         end
         #1;
         if (mem_rd || mem_wr) begin
            if (req_cyc == 0) held_addr = mem_addr;
            else if (mem_addr !== held_addr) moved = 1;
            req_cyc++;
         end
         n_alu += int'(alu_en); n_inc += int'(pc_inc); n_load += int'(pc_load);
         n_ir += int'(ir_cmd); n_src += int'(src_ld); n_dst += int'(dst_ld);
         n_both += int'(pc_inc && pc_load);
         if ((mem_rd || mem_wr) && mem_ready) begin
            check({tag, "_acc_expected"}, exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               exp_acc = exp_q.pop_front();
               check({tag, "_acc"}, {mem_wr, mem_addr}, exp_acc);
               check({tag, "_req_held"}, req_cyc, w + 1);
               check({tag, "_addr_stable"}, moved, 0);
            end
            acc++; wcnt = 0; req_cyc = 0; moved = 0;
         end
         if (pc_inc) pc_model = pc_model + 1'b1;
         if (pc_load) pc_model = da;
         cyc++;
         @(posedge clock);
         #1;
         mem_ready = 1'b0;
         if (dbg_state != ST_FETCH) left = 1;
         if (dbg_state == ST_HALT || dbg_state == ST_WAIT || (left && dbg_state == ST_FETCH))
            done = 1;
      end
      check({tag, "_finished"}, done, 1);
      check({tag, "_cycles"}, cyc, exp_cyc);
      check({tag, "_q_empty"}, exp_q.size(), 0);
      check({tag, "_alu_en"}, n_alu, is_alu ? 1 : 0);
      check({tag, "_pc_inc"}, n_inc, 1);
      check({tag, "_pc_load"}, n_load, taken ? 1 : 0);
      check({tag, "_ir_cmd"}, n_ir, 1);
      check({tag, "_src_ld"}, n_src, (is_alu || is_mov) ? 1 : 0);
      check({tag, "_dst_ld"}, n_dst, is_alu ? 1 : 0);
      check({tag, "_inc_load_overlap"}, n_both, 0);
      exp_q.delete();
   endtask

   initial begin
      int n_act;
      bit seen_wr;
      logic [3:0] r_op;
      reset = 1'b0; op = '0; cc = '0; s_a = '0; de_a = '0; flags = '0; mem_ready = 1'b0;
      pc_model = 12'h100; pc = pc_model;
`ifdef SINGLE_STEP_EN
      step = 1'b0;
`endif
      // Power-up reset.
      repeat (2) @(posedge clock);
      @(negedge clock); #1;
      check("por_outs", outs_vec(), 0);
      check("por_state", dbg_state, ST_IDLE);
      check("por_addr", mem_addr, 0);
      reset = 1'b1;

`ifdef SINGLE_STEP_EN
      n_act = 0;
      repeat (10) begin
         @(negedge clock); #1;
         n_act += int'(mem_rd);
      end
      check("step_low_no_rd", n_act, 0);
      check("step_low_wait", dbg_state, ST_WAIT);
`endif

      run_instr("alu0",  4'h1, 4'h0,    12'h010, 12'h020, 4'h0,    0, 0);
      run_instr("alu_ws", 4'h1, 4'h0,   12'h010, 12'h020, 4'h0,    3, 0);
      run_instr("mov",   4'h8, 4'h0,    12'h033, 12'h044, 4'h0,    0, 0);
      run_instr("jmp_z", 4'h9, 4'b0100, 12'h000, 12'h200, 4'b0100, 0, 0);
      run_instr("jmp_nt", 4'h9, 4'b0100, 12'h000, 12'h300, 4'b0000, 0, 0);
      run_instr("jmp_al", 4'h9, 4'b0000, 12'h000, 12'h400, 4'b0000, 0, 0);
      run_instr("jmp_n", 4'h9, 4'b1000, 12'h000, 12'h0AB, 4'b1001, 0, 0);
      run_instr("nop",   4'h0, 4'h0,    12'h000, 12'h000, 4'h0,    0, 0);
      run_instr("ill_c", 4'hC, 4'h0,    12'h055, 12'h066, 4'h0,    0, 0);
      for (int i = 0; i < 12; i++) begin
         r_op = 4'($urandom_range(0, 14));
         run_instr($sformatf("rnd%0d", i), r_op, 4'($urandom_range(0, 15)),
                   12'($urandom), 12'($urandom), 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)), 1);
      end

      // Reset in the middle of a stalled write-back.
      op = 4'h2; s_a = 12'h0F0; de_a = 12'h0E0;
      step_release();
      seen_wr = 0;
      for (int c = 0; c < 30 && !seen_wr; c++) begin
         @(negedge clock);
         pc = pc_model;
         mem_ready = mem_rd;
         #1;
         if (mem_wr) seen_wr = 1;
         else begin
            if (pc_inc) pc_model = pc_model + 1'b1;
            @(posedge clock); #1;
            mem_ready = 1'b0;
         end
      end
      mem_ready = 1'b0;
      #1;
      check("midrst_in_wr", mem_wr, 1);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock); #1;
      check("midrst_outs", outs_vec(), 0);
      check("midrst_state", dbg_state, ST_IDLE);
      check("midrst_addr", mem_addr, 0);
      reset = 1'b1;
      @(negedge clock); #1;
`ifdef SINGLE_STEP_EN
      check("postrst_rd", mem_rd, 0);
`else
      check("postrst_rd", mem_rd, 1);
      check("postrst_addr", mem_addr, pc_model);
`endif

      // Halt: no further activity for 20 cycles even with memory ready.
      run_instr("hlt", 4'hF, 4'h0, 12'h000, 12'h000, 4'h0, 0, 0);
      n_act = 0;
      repeat (20) begin
         @(negedge clock);
         mem_ready = 1'b1;
         #1;
         n_act += int'(outs_vec() != 9'b000000001);
      end
      mem_ready = 1'b0;
      check("hlt_quiet", n_act, 0);
      check("hlt_halted", halted, 1);
      check("hlt_state", dbg_state, ST_HALT);
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock); #1;
      check("hlt_rst_outs", outs_vec(), 0);
      check("hlt_rst_state", dbg_state, ST_IDLE);
      reset = 1'b1;
      run_instr("post_hlt", 4'h1, 4'h0, 12'h111, 12'h222, 4'h0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
